// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding and constants for the 16-bit asynchronous SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic PH_LOW  = 1'b0;
  localparam logic PH_HIGH = 1'b1;

  localparam int DEFAULT_BASE_ADDR = 1024;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter; terminal flags the last cycle a half-word phase is held.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [3:0] count;

  always_ff @(posedge clk) begin
    if (rst)         count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 4'd1;
  end

  assign terminal = (count == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Splits each 32-bit LDR/STR into two half-word SRAM phases and freezes the pipeline via ready.
module sram_controller
  import sram_ctrl_pkg::*;
#(
  parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  state_t state, state_d;
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic        op_wr, op_wr_d;
  logic        busy, terminal;

  logic               active_d, phase_d;
  logic [SRAM_AW-2:0] word_d;

  assign busy = (state == ST_LOW) || (state == ST_HIGH);

  sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .clear    (~busy | terminal),
    .enable   (busy),
    .terminal (terminal)
  );

  always_comb begin
    state_d = state;
    addr_d  = addr_q;
    data_d  = data_q;
    op_wr_d = op_wr;
    case (state)
      ST_IDLE: if (rd_en | wr_en) begin
        addr_d  = address;
        data_d  = write_data;
        op_wr_d = wr_en;
        state_d = ST_LOW;
      end
      ST_LOW:  if (terminal) state_d = ST_HIGH;
      ST_HIGH: if (terminal) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pins are registered from the next state so strobes change cleanly on the phase edge.
  always_comb begin
    active_d = (state_d == ST_LOW) || (state_d == ST_HIGH);
    phase_d  = (state_d == ST_HIGH) ? PH_HIGH : PH_LOW;
    word_d   = (SRAM_AW-1)'((addr_d - 32'(BASE_ADDR)) >> 2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      op_wr      <= 1'b0;
      read_data  <= '0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
    end else begin
      state      <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      op_wr      <= op_wr_d;
      sram_addr  <= {word_d, phase_d};
      sram_dq_o  <= (phase_d == PH_HIGH) ? data_d[31:16] : data_d[15:0];
      sram_dq_oe <= active_d & op_wr_d;
      sram_ce_n  <= ~active_d;
      sram_oe_n  <= ~(active_d & ~op_wr_d);
      sram_we_n  <= ~(active_d & op_wr_d);
      if (state == ST_LOW && terminal && !op_wr)  read_data[15:0]  <= sram_dq_i;
      if (state == ST_HIGH && terminal && !op_wr) read_data[31:16] <= sram_dq_i;
    end
  end

  assign ready     = (state == ST_IDLE) ? ~(rd_en | wr_en) : (state == ST_DONE);
  assign sram_ub_n = 1'b0;
  assign sram_lb_n = 1'b0;

endmodule
